// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and helpers for the APB completer: FSM state
//                encoding, pslverr response codes and the byte-offset width
//                derivation used by the address decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // pslverr response codes
    localparam logic c_OKAY  = 1'b0;
    localparam logic c_ERROR = 1'b1;

    // Number of paddr bits that select a byte within one data word
    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile
//  Description : NUM_REGS x DATA register bank with one byte-strobed write
//                port, one indexed read port and a flat view of every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DATA     = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_widx,
    input  logic [DATA-1:0]          i_wdata,
    input  logic [DATA/8-1:0]        i_strb,
    input  logic [IDX_W-1:0]         i_ridx,
    output logic [DATA-1:0]          o_rdata,
    output logic [NUM_REGS*DATA-1:0] o_regs
);

    localparam int BYTES = DATA / 8;

    logic [DATA-1:0] r_mem [NUM_REGS];

    // Register storage: clear on reset, otherwise write only the enabled lanes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_strb[b]) begin
                    r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign o_regs[g*DATA +: DATA] = r_mem[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave
//  Description : APB completer decoding transfers into a bank of NUM_REGS
//                registers, with WAIT_CYCLES wait states, pslverr on
//                out-of-range or misaligned accesses, and a flat register
//                output for downstream configuration logic.
//                Define APB_PSTRB_EN to add the pstrb byte-strobe port.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave
    import apb_pkg::*;
#(
    parameter int DATA        = 32,
    parameter int ADDR        = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [ADDR-1:0]          paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [DATA-1:0]          pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA/8-1:0]        pstrb,
`endif
    output logic [DATA-1:0]          prdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [NUM_REGS*DATA-1:0] regs
);

    localparam int   BYTES       = DATA / 8;
    localparam int   ADDR_LSB    = addr_lsb(DATA);
    localparam int   IDX_W       = $clog2(NUM_REGS);
    localparam int   HI_LSB      = ADDR_LSB + IDX_W;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic c_ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_write, w_write_nxt;
    logic              r_err, w_err_nxt;
    logic [DATA-1:0]   r_wdata, w_wdata_nxt;
    logic [BYTES-1:0]  r_strb, w_strb_nxt;
    logic [BYTES-1:0]  w_strb_in;

    logic              w_misalign;
    logic              w_oor;
    logic              w_addr_err;
    logic              w_we;
    logic [DATA-1:0]   w_rdata;

    logic              r_pready;
    logic              r_pslverr;
    logic [DATA-1:0]   r_prdata;

`ifdef APB_PSTRB_EN
    assign w_strb_in = pstrb;
`else
    assign w_strb_in = '1;
`endif

    // Byte-offset bits below the word boundary must be zero
    generate
        if (ADDR_LSB > 0) begin : g_align
            assign w_misalign = |paddr[ADDR_LSB-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
    endgenerate

    // Any set bit above the register index lands past the last register
    generate
        if (ADDR > HI_LSB) begin : g_range
            assign w_oor = |paddr[ADDR-1:HI_LSB];
        end else begin : g_no_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_addr_err = w_misalign | w_oor;

    // Next-state, wait counter and setup-phase capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_write_nxt = r_write;
        w_err_nxt   = r_err;
        w_wdata_nxt = r_wdata;
        w_strb_nxt  = r_strb;
        case (r_state)
            IDLE: begin
                // psel with penable already high is not a setup cycle; ignore it
                if (psel && !penable) begin
                    w_idx_nxt   = paddr[ADDR_LSB +: IDX_W];
                    w_write_nxt = pwrite;
                    w_err_nxt   = w_addr_err;
                    w_wdata_nxt = pwdata;
                    w_strb_nxt  = w_strb_in;
                    if (c_ZERO_WAIT) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt   = c_WAIT_LOAD;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (!psel) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and captured transfer attributes
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_write <= w_write_nxt;
            r_err   <= w_err_nxt;
            r_wdata <= w_wdata_nxt;
            r_strb  <= w_strb_nxt;
        end
    end

    // Commit only when the master still holds the access phase at the end of RESP
    assign w_we = (r_state == RESP) && psel && penable && r_write && !r_err;

    // Registered response: valid for the single RESP cycle, prdata holds afterwards
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_pready  <= 1'b0;
            r_pslverr <= c_OKAY;
            r_prdata  <= '0;
        end else begin
            r_pready  <= (w_state_nxt == RESP);
            r_pslverr <= ((w_state_nxt == RESP) && w_err_nxt) ? c_ERROR : c_OKAY;
            if (w_state_nxt == RESP) begin
                r_prdata <= (!w_write_nxt && !w_err_nxt) ? w_rdata : '0;
            end
        end
    end

    apb_regfile #(
        .DATA     (DATA),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_strb  (r_strb),
        .i_ridx  (w_idx_nxt),
        .o_rdata (w_rdata),
        .o_regs  (regs)
    );

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_slave
//  Description : Self-checking bench for apb_slave. Three instances with
//                WAIT_CYCLES = 0, 3 and 2 share the bus (separate psel).
//                A reference register model produces the expected response
//                of each transfer, queued before the transfer is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] paddr;
    logic        penable, pwrite;
    logic [31:0] pwdata;
    logic        psel0, psel1, psel2;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb;
`endif
    logic [31:0]  prdata0, prdata1, prdata2;
    logic         pready0, pready1, pready2;
    logic         pslverr0, pslverr1, pslverr2;
    logic [255:0] regs0, regs1, regs2;

    always #5 pclk = ~pclk;

    apb_slave #(.DATA(32), .ADDR(32), .NUM_REGS(8), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .regs(regs0));

    apb_slave #(.DATA(32), .ADDR(32), .NUM_REGS(8), .WAIT_CYCLES(3)) u_dut1 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .regs(regs1));

    apb_slave #(.DATA(32), .ADDR(32), .NUM_REGS(8), .WAIT_CYCLES(2)) u_dut2 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2), .regs(regs2));

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
    } stim_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [3][8];
    int          n_err = 0;
    int          n_chk = 0;

    logic        obs_ok;
    int          obs_lat;
    logic        obs_err;
    logic [31:0] obs_rdata;

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : (d == 1) ? pready1 : pready2;
    endfunction

    function automatic logic err_of(input int d);
        return (d == 0) ? pslverr0 : (d == 1) ? pslverr1 : pslverr2;
    endfunction

    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? prdata0 : (d == 1) ? prdata1 : prdata2;
    endfunction

    function automatic logic [255:0] flat(input int d);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mdl[d][i];
        return f;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
    endtask

    // Reference behaviour: expected response queued, model updated for writes
    task automatic push_exp(input int d, input stim_t s);
        exp_t       e;
        logic [3:0] st_eff;
        e.err   = (s.a >= 32'd32) || (s.a[1:0] != 2'b00);
        e.rdata = (!s.wr && !e.err) ? mdl[d][s.a[4:2]] : 32'h0;
        e.lat   = (d == 0) ? 1 : (d == 1) ? 4 : 3;
        e.name  = $sformatf("d%0d_%s_%08h", d, s.wr ? "wr" : "rd", s.a);
`ifdef APB_PSTRB_EN
        st_eff = s.st;
`else
        st_eff = 4'hF;
`endif
        if (s.wr && !e.err)
            for (int b = 0; b < 4; b++)
                if (st_eff[b]) mdl[d][s.a[4:2]][b*8 +: 8] = s.wd[b*8 +: 8];
        exp_q.push_back(e);
    endtask

    task automatic set_psel(input int d, input logic on);
        psel0 = on && (d == 0);
        psel1 = on && (d == 1);
        psel2 = on && (d == 2);
    endtask

    // One transfer; returns at the negedge inside the first pready=1 cycle
    task automatic xfer(input int d, input stim_t s);
        int k;
        @(negedge pclk);
        paddr   = s.a;
        pwrite  = s.wr;
        pwdata  = s.wd;
`ifdef APB_PSTRB_EN
        pstrb   = s.st;
`endif
        penable = 1'b0;
        set_psel(d, 1'b1);
        @(negedge pclk);
        penable = 1'b1;
        k = 1;
        while (!rdy(d) && k < 40) begin
            @(negedge pclk);
            k++;
        end
        obs_ok    = rdy(d);
        obs_lat   = k;
        obs_err   = err_of(d);
        obs_rdata = rd_of(d);
    endtask

    task automatic idle();
        @(negedge pclk);
        set_psel(0, 1'b0);
        penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        n_chk++; if (pready0 !== 1'b0 || pready1 !== 1'b0 || pready2 !== 1'b0) begin
            n_err++; $display("FAIL reset_pready: got %b%b%b required 000", pready0, pready1, pready2); end
        n_chk++; if (pslverr0 !== 1'b0 || pslverr1 !== 1'b0 || pslverr2 !== 1'b0) begin
            n_err++; $display("FAIL reset_pslverr: got %b%b%b required 000", pslverr0, pslverr1, pslverr2); end
        n_chk++; if (prdata0 !== 32'h0 || prdata1 !== 32'h0 || prdata2 !== 32'h0) begin
            n_err++; $display("FAIL reset_prdata: got %h %h %h required 0", prdata0, prdata1, prdata2); end
        n_chk++; if (regs0 !== 256'h0 || regs1 !== 256'h0 || regs2 !== 256'h0) begin
            n_err++; $display("FAIL reset_regs: got %h required 0", regs0 | regs1 | regs2); end
        preset = 1'b0;
        clear_model();
    endtask

    task automatic test_zero_wait();
        stim_t tab[5] = '{
            '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF},
            '{1'b0, 32'h00, 32'h0,        4'hF},
            '{1'b1, 32'h1C, 32'h12345678, 4'hF},
            '{1'b0, 32'h1C, 32'h0,        4'hF},
            '{1'b0, 32'h04, 32'h0,        4'hF}};
        exp_t e;
        foreach (tab[i]) begin
            push_exp(0, tab[i]);
            xfer(0, tab[i]);
            e = exp_q.pop_front();
            n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
                n_err++; $display("FAIL %s latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
            n_chk++; if (obs_err !== e.err) begin
                n_err++; $display("FAIL %s pslverr: got %b required %b", e.name, obs_err, e.err); end
            n_chk++; if (obs_rdata !== e.rdata) begin
                n_err++; $display("FAIL %s prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
            idle();
        end
        n_chk++; if (pready0 !== 1'b0) begin
            n_err++; $display("FAIL zw_pready_drop: got %b required 0", pready0); end
        n_chk++; if (prdata0 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL zw_prdata_hold: got %h required deadbeef", prdata0); end
        n_chk++; if (regs0[63:32] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL zw_reg1: got %h required deadbeef", regs0[63:32]); end
        n_chk++; if (regs0 !== flat(0)) begin
            n_err++; $display("FAIL zw_regs: got %h required %h", regs0, flat(0)); end
    endtask

    task automatic test_back_to_back();
        stim_t tab[5] = '{
            '{1'b1, 32'h10, 32'hA5A5A5A5, 4'hF},
            '{1'b0, 32'h10, 32'h0,        4'hF},
            '{1'b1, 32'h14, 32'h5A5A5A5A, 4'hF},
            '{1'b0, 32'h14, 32'h0,        4'hF},
            '{1'b0, 32'h10, 32'h0,        4'hF}};
        exp_t e;
        foreach (tab[i]) begin
            push_exp(0, tab[i]);
            xfer(0, tab[i]);
            e = exp_q.pop_front();
            n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
                n_err++; $display("FAIL %s b2b_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
            n_chk++; if (obs_err !== e.err) begin
                n_err++; $display("FAIL %s b2b_pslverr: got %b required %b", e.name, obs_err, e.err); end
            n_chk++; if (obs_rdata !== e.rdata) begin
                n_err++; $display("FAIL %s b2b_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        end
        idle();
        n_chk++; if (regs0 !== flat(0)) begin
            n_err++; $display("FAIL b2b_regs: got %h required %h", regs0, flat(0)); end
    endtask

    task automatic test_errors();
        stim_t tab[6] = '{
            '{1'b1, 32'h20,       32'hFFFFFFFF, 4'hF},
            '{1'b0, 32'h06,       32'h0,        4'hF},
            '{1'b1, 32'h05,       32'h11111111, 4'hF},
            '{1'b0, 32'h1C,       32'h0,        4'hF},
            '{1'b0, 32'h20,       32'h0,        4'hF},
            '{1'b1, 32'hFFFFFFFC, 32'h22222222, 4'hF}};
        exp_t e;
        foreach (tab[i]) begin
            push_exp(0, tab[i]);
            xfer(0, tab[i]);
            e = exp_q.pop_front();
            n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
                n_err++; $display("FAIL %s err_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
            n_chk++; if (obs_err !== e.err) begin
                n_err++; $display("FAIL %s err_pslverr: got %b required %b", e.name, obs_err, e.err); end
            n_chk++; if (obs_rdata !== e.rdata) begin
                n_err++; $display("FAIL %s err_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        end
        idle();
        n_chk++; if (pslverr0 !== 1'b0 || pready0 !== 1'b0) begin
            n_err++; $display("FAIL err_drop: got pslverr=%b pready=%b required 0 0", pslverr0, pready0); end
        n_chk++; if (regs0 !== flat(0)) begin
            n_err++; $display("FAIL err_regs_unchanged: got %h required %h", regs0, flat(0)); end
    endtask

    task automatic test_wait_states();
        stim_t tab[5] = '{
            '{1'b0, 32'h00, 32'h0,        4'hF},
            '{1'b1, 32'h08, 32'hCAFEF00D, 4'hF},
            '{1'b0, 32'h08, 32'h0,        4'hF},
            '{1'b1, 32'h24, 32'h33333333, 4'hF},
            '{1'b0, 32'h08, 32'h0,        4'hF}};
        exp_t e;
        foreach (tab[i]) begin
            push_exp(1, tab[i]);
            xfer(1, tab[i]);
            e = exp_q.pop_front();
            n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
                n_err++; $display("FAIL %s ws_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
            n_chk++; if (obs_err !== e.err) begin
                n_err++; $display("FAIL %s ws_pslverr: got %b required %b", e.name, obs_err, e.err); end
            n_chk++; if (obs_rdata !== e.rdata) begin
                n_err++; $display("FAIL %s ws_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        end
        idle();
        n_chk++; if (regs1 !== flat(1)) begin
            n_err++; $display("FAIL ws_regs: got %h required %h", regs1, flat(1)); end
    endtask

    task automatic test_abort();
        stim_t s_rd8 = '{1'b0, 32'h08, 32'h0, 4'hF};
        stim_t s_rdc = '{1'b0, 32'h0C, 32'h0, 4'hF};
        exp_t  e;
        logic  seen;
        // Write to 0x08 abandoned by dropping psel while waiting
        @(negedge pclk);
        paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h0BADF00D; penable = 1'b0;
`ifdef APB_PSTRB_EN
        pstrb = 4'hF;
`endif
        set_psel(2, 1'b1);
        @(negedge pclk);
        penable = 1'b1;
        seen = pready2;
        @(negedge pclk);
        seen = seen | pready2;
        set_psel(2, 1'b0);
        penable = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            seen = seen | pready2;
        end
        n_chk++; if (seen !== 1'b0) begin
            n_err++; $display("FAIL abort_pready: got %b required 0", seen); end
        n_chk++; if (regs2[95:64] !== mdl[2][2]) begin
            n_err++; $display("FAIL abort_reg2: got %h required %h", regs2[95:64], mdl[2][2]); end
        push_exp(2, s_rd8);
        xfer(2, s_rd8);
        e = exp_q.pop_front();
        n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
            n_err++; $display("FAIL %s post_abort_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
        n_chk++; if (obs_rdata !== e.rdata) begin
            n_err++; $display("FAIL %s post_abort_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        idle();
        // Reset while waiting, master keeps psel/penable asserted afterwards
        @(negedge pclk);
        paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h77777777; penable = 1'b0;
        set_psel(2, 1'b1);
        @(negedge pclk);
        penable = 1'b1;
        preset  = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        clear_model();
        seen = pready2 | pslverr2;
        repeat (4) begin
            @(negedge pclk);
            seen = seen | pready2 | pslverr2;
        end
        n_chk++; if (seen !== 1'b0) begin
            n_err++; $display("FAIL rst_wait_idle: got pready|pslverr=%b required 0", seen); end
        n_chk++; if (regs2 !== flat(2)) begin
            n_err++; $display("FAIL rst_wait_regs: got %h required %h", regs2, flat(2)); end
        idle();
        push_exp(2, s_rdc);
        xfer(2, s_rdc);
        e = exp_q.pop_front();
        n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
            n_err++; $display("FAIL %s post_rst_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
        n_chk++; if (obs_rdata !== e.rdata) begin
            n_err++; $display("FAIL %s post_rst_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        idle();
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        stim_t tab[5] = '{
            '{1'b1, 32'h0C, 32'h11223344, 4'hF},
            '{1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101},
            '{1'b0, 32'h0C, 32'h0,        4'h0},
            '{1'b1, 32'h0C, 32'h99999999, 4'h0},
            '{1'b0, 32'h0C, 32'h0,        4'h3}};
        exp_t e;
        foreach (tab[i]) begin
            push_exp(0, tab[i]);
            xfer(0, tab[i]);
            e = exp_q.pop_front();
            n_chk++; if (obs_ok !== 1'b1 || obs_lat != e.lat) begin
                n_err++; $display("FAIL %s strb_latency: got ready=%b cycles=%0d required cycles=%0d", e.name, obs_ok, obs_lat, e.lat); end
            n_chk++; if (obs_err !== e.err) begin
                n_err++; $display("FAIL %s strb_pslverr: got %b required %b", e.name, obs_err, e.err); end
            n_chk++; if (obs_rdata !== e.rdata) begin
                n_err++; $display("FAIL %s strb_prdata: got %h required %h", e.name, obs_rdata, e.rdata); end
        end
        idle();
        n_chk++; if (regs0[127:96] !== 32'h11BB33DD) begin
            n_err++; $display("FAIL strb_reg3: got %h required 11bb33dd", regs0[127:96]); end
        n_chk++; if (regs0 !== flat(0)) begin
            n_err++; $display("FAIL strb_regs: got %h required %h", regs0, flat(0)); end
    endtask
`endif

    initial begin
        paddr = 32'h0; pwrite = 1'b0; pwdata = 32'h0; penable = 1'b0;
`ifdef APB_PSTRB_EN
        pstrb = 4'hF;
`endif
        set_psel(0, 1'b0);
        preset = 1'b1;
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_errors();
        test_wait_states();
        test_abort();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/apb_slave.md
Name: apb_slave

Overview:
- APB completer (slave): the responder end of the APB bus driven by the team's APB master.
- Decodes each transfer into a bank of NUM_REGS read/write registers.
- Inserts a configurable number of wait states through pready.
- Flags bad accesses through pslverr.
- Exposes the full register bank as a flat output, so downstream logic can consume configuration values.

Parameters:
- DATA, 32, data bus width in bits; must be a multiple of 8.
- ADDR, 32, address bus width in bits.
- NUM_REGS, 8, number of DATA-wide registers; power of two, 2..256.
- WAIT_CYCLES, 0, wait states inserted per transfer; range 0..15.

Ports:
- pclk  input  1  bus clock; all logic on rising edge.
- preset  input  1  reset, synchronous, active-high.
- paddr  input  ADDR  byte address.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA  write data.
- prdata  output  DATA  read data; valid when pready=1 and the transfer is a read.
- pready  output  1  transfer-complete indication.
- pslverr  output  1  error response; valid only when pready=1.
- regs  output  NUM_REGS*DATA  flat register bank; register i occupies bits [i*DATA +: DATA].

Behaviour:
- Clock and reset: one clock, pclk. Reset preset is synchronous and active-high.
- Reset values:
  - state = IDLE; pready = 0; pslverr = 0; prdata = 0.
  - All registers = 0; wait counter = 0.
  - Reset mid-transfer abandons the transfer; no write commits.
- Addressing:
  - ADDR_LSB = log2(DATA/8).
  - Register index = paddr[ADDR_LSB +: log2(NUM_REGS)].
  - Error access: paddr >= NUM_REGS*(DATA/8), or paddr[ADDR_LSB-1:0] != 0 (misaligned).
- All outputs are registered. FSM states: IDLE, WAIT, RESP.
- IDLE:
  - pready = 0.
  - On psel=1 and penable=0 (setup cycle): capture paddr, pwrite, pwdata and the error flag.
  - Then, if WAIT_CYCLES = 0, go to RESP. Else load counter = WAIT_CYCLES and go to WAIT.
  - psel=1 with penable=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - pready = 0; counter decrements each cycle.
  - At counter = 1, go to RESP.
  - psel=0 in any cycle: abort to IDLE; no write, no response.
- RESP:
  - pready = 1 for exactly one cycle.
  - pslverr = captured error flag.
  - prdata = register[index] for a clean read; 0 for a write or an error.
  - Write commits at the rising edge ending RESP, only if psel=1, penable=1, write, and no error.
  - Always returns to IDLE. pready and pslverr return to 0 the next cycle; prdata holds until the next response.
- Latency:
  - Transfer completes in 2+WAIT_CYCLES cycles from the setup cycle.
  - WAIT_CYCLES = 0 means pready is high in the first access cycle (zero-wait).
- Back-to-back: a new setup in the cycle after RESP is accepted from IDLE with no bubble.
- Error writes never modify any register. Reads have no side effects.
- regs reflects register contents combinationally from the flops; it updates the cycle after a write commits.

Optional Feature:
- Macro APB_PSTRB_EN.
- Defined:
  - Adds port pstrb input DATA/8, byte write strobes.
  - pstrb is captured in setup. Only byte lanes with pstrb[b]=1 are written; others hold.
  - pstrb is ignored on reads.
  - A write with pstrb = 0 completes normally with no register change.
- Undefined: no pstrb port; every write updates the full word.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - ADDR_LSB derivation helper;
  - OKAY/ERROR constants for pslverr.
- Sub-module apb_regfile: NUM_REGS x DATA flops.
  - Inputs: write-enable, index, wdata, optional byte strobe.
  - Outputs: read port by index, flat regs output.
  - apb_slave keeps the FSM, decode and wait counter.

Test Plan:
- Reset: hold preset=1 for 2 cycles -> pready=0, pslverr=0, prdata=0, regs all 0.
- Zero-wait write then read, WAIT_CYCLES=0: write paddr=0x04, pwdata=0xDEADBEEF -> pready=1 in first access cycle, pslverr=0, regs[63:32]=0xDEADBEEF. Read 0x04 -> prdata=0xDEADBEEF.
- Wait states, WAIT_CYCLES=3: read 0x00 -> pready low for 3 access cycles, high on the 4th (5 cycles total from setup).
- Errors:
  - Write paddr=0x20 (NUM_REGS=8) -> pslverr=1 with pready, no register changes.
  - Read paddr=0x06 (misaligned) -> pslverr=1, prdata=0.
- Abort, WAIT_CYCLES=2: drop psel during WAIT of a write to 0x08 -> FSM returns to IDLE, regs[95:64] unchanged. Then reset mid-WAIT -> state IDLE, pready=0.
- APB_PSTRB_EN: reg 0x0C = 0x11223344; write 0xAABBCCDD with pstrb=4'b0101 -> register = 0x11BB33DD.
